// File: rtl/pixel_gen_rtc.sv
// pixel_gen_rtc: draws the "HH:MM:SS" string as x4-scaled 8x16 glyphs.
// The path from pixel_X/pixel_Y to rgb is two registers deep, and the syncs
// are delayed by the same two stages. Digits come from shadow copies of the
// time inputs that are reloaded once per frame. The edited field blinks.
module pixel_gen_rtc #(
  parameter int          X0           = 192,
  parameter int          Y0           = 208,
  parameter logic [11:0] FG           = 12'hFFF,
  parameter logic [11:0] EDIT_FG      = 12'hF80,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  pixel_X,
  input  logic [9:0]  pixel_Y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  hora,
  input  logic [7:0]  min,
  input  logic [7:0]  seg,
  input  logic        edit_mode,
  input  logic [1:0]  campo_sel,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int            CW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [10:0]   X0_L       = 11'(X0);
  localparam logic [10:0]   X1_L       = 11'(X0 + 256);
  localparam logic [10:0]   Y0_L       = 11'(Y0);
  localparam logic [10:0]   Y1_L       = 11'(Y0 + 64);
  localparam logic [3:0]    G_COLON    = 4'd10;
  localparam logic [3:0]    G_BLANK    = 4'd15;
  localparam logic [1:0]    F_NONE     = 2'd3;

  // Font ROM: one 128-bit word per glyph, row 0 in the top byte.
  // Any code outside 0..10 reads as a blank glyph.
  function automatic logic [7:0] font_row_bits(input logic [3:0] code, input logic [3:0] row);
    logic [127:0] g;
    case (code)
      4'd0:    g = 128'h00007CC6_C6CEDEF6_E6C6C67C_00000000;
      4'd1:    g = 128'h00001838_78181818_1818187E_00000000;
      4'd2:    g = 128'h00007CC6_060C1830_60C0C6FE_00000000;
      4'd3:    g = 128'h00007CC6_06063C06_0606C67C_00000000;
      4'd4:    g = 128'h00000C1C_3C6CCCFE_0C0C0C1E_00000000;
      4'd5:    g = 128'h0000FEC0_C0C0FC06_0606C67C_00000000;
      4'd6:    g = 128'h00003860_C0C0FCC6_C6C6C67C_00000000;
      4'd7:    g = 128'h0000FEC6_06060C18_30303030_00000000;
      4'd8:    g = 128'h00007CC6_C6C67CC6_C6C6C67C_00000000;
      4'd9:    g = 128'h00007CC6_C6C67E06_06060C78_00000000;
      4'd10:   g = 128'h00000000_18180000_00001818_00000000;
      default: g = '0;
    endcase
    return g[{4'd15 - row, 3'b000} +: 8];
  endfunction

  // shadow time, frame edge detector, blink state
  logic [7:0]    sh_hora_q, sh_hora_d, sh_min_q, sh_min_d, sh_seg_q, sh_seg_d;
  logic          fp_prev_q, fp_prev_d, fp_cond, frame_pulse;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  // stage 1
  logic          vis_q, vis_d, box_q, box_d;
  logic [3:0]    glyph_q, glyph_d, row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [1:0]    field_q, field_d, edit_sel_q, edit_sel_d;
  logic [10:0]   px, py, dx, dy;
  logic [2:0]    chr;
  logic [3:0]    nib;
  logic          is_colon;
  // stage 2 and sync delay
  logic [11:0]   rgb_q, rgb_d;
  logic [7:0]    rom_bits;
  logic          pix_on, edited;
  logic [1:0]    hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

  // Once per frame: reload the shadow time and advance the blink phase.
  always_comb begin
    fp_cond     = (pixel_Y == 10'd480) && (pixel_X == 10'd0);
    frame_pulse = fp_cond && !fp_prev_q;
    fp_prev_d   = fp_cond;
    sh_hora_d   = sh_hora_q;
    sh_min_d    = sh_min_q;
    sh_seg_d    = sh_seg_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_pulse) begin
      sh_hora_d = hora;
      sh_min_d  = min;
      sh_seg_d  = seg;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: classify the pixel and find its glyph, font cell and field.
  always_comb begin
    px       = {1'b0, pixel_X};
    py       = {1'b0, pixel_Y};
    dx       = px - X0_L;
    dy       = py - Y0_L;
    vis_d    = (pixel_X < 10'd640) && (pixel_Y < 10'd480);
    box_d    = (px >= X0_L) && (px < X1_L) && (py >= Y0_L) && (py < Y1_L);
    chr      = 3'(dx >> 5);
    col_d    = 3'(dx >> 2);
    row_d    = 4'(dy >> 2);
    nib      = 4'd0;
    is_colon = 1'b0;
    field_d  = F_NONE;
    case (chr)
      3'd0:    begin nib = sh_hora_q[7:4]; field_d = 2'd0; end
      3'd1:    begin nib = sh_hora_q[3:0]; field_d = 2'd0; end
      3'd3:    begin nib = sh_min_q[7:4];  field_d = 2'd1; end
      3'd4:    begin nib = sh_min_q[3:0];  field_d = 2'd1; end
      3'd6:    begin nib = sh_seg_q[7:4];  field_d = 2'd2; end
      3'd7:    begin nib = sh_seg_q[3:0];  field_d = 2'd2; end
      default: is_colon = 1'b1;
    endcase
    if (is_colon)         glyph_d = G_COLON;
    else if (nib > 4'd9)  glyph_d = G_BLANK;
    else                  glyph_d = nib;
    // campo_sel==3 selects nothing, so it behaves like edit_mode=0
    edit_sel_d = edit_mode ? campo_sel : F_NONE;
    hs_pipe_d  = {hs_pipe_q[0], hsync_in};
    vs_pipe_d  = {vs_pipe_q[0], vsync_in};
  end

  // Stage 2: font lookup, bit select and colour choice.
  always_comb begin
    rom_bits = font_row_bits(glyph_q, row_q);
    pix_on   = rom_bits[3'd7 - col_q];
    edited   = (field_q != F_NONE) && (field_q == edit_sel_q);
    rgb_d    = 12'h000;
    if (vis_q && box_q && pix_on) begin
      if (!edited)         rgb_d = FG;
      else if (blink_on_q) rgb_d = EDIT_FG;
    end
  end

  // All state; reset drops the pipeline and restores the power-up display.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_hora_q   <= 8'h00;
      sh_min_q    <= 8'h00;
      sh_seg_q    <= 8'h00;
      fp_prev_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      vis_q       <= 1'b0;
      box_q       <= 1'b0;
      glyph_q     <= 4'd0;
      row_q       <= 4'd0;
      col_q       <= 3'd0;
      field_q     <= F_NONE;
      edit_sel_q  <= F_NONE;
      rgb_q       <= 12'h000;
      hs_pipe_q   <= 2'b11;
      vs_pipe_q   <= 2'b11;
    end else begin
      sh_hora_q   <= sh_hora_d;
      sh_min_q    <= sh_min_d;
      sh_seg_q    <= sh_seg_d;
      fp_prev_q   <= fp_prev_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      vis_q       <= vis_d;
      box_q       <= box_d;
      glyph_q     <= glyph_d;
      row_q       <= row_d;
      col_q       <= col_d;
      field_q     <= field_d;
      edit_sel_q  <= edit_sel_d;
      rgb_q       <= rgb_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs_pipe_q[1];
  assign vsync_out = vs_pipe_q[1];

endmodule

// File: tb/tb_pixel_gen_rtc.sv
// tb_pixel_gen_rtc: random and directed pixel stimulus. Each pixel's expected
// rgb/sync is computed from a behavioural model of the clock display and
// queued with its due cycle; a monitor compares it when the cycle arrives.
module tb_pixel_gen_rtc;
  localparam int          X0  = 192;
  localparam int          Y0  = 208;
  localparam int          BF  = 30;
  localparam logic [11:0] FG  = 12'hFFF;
  localparam logic [11:0] EFG = 12'hF80;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic [9:0]  px = '0, py = '0;
  logic        hs = 1'b1, vs = 1'b1;
  logic [7:0]  hora = '0, mn = '0, sg = '0;
  logic        edit = 1'b0;
  logic [1:0]  campo = 2'd3;
  logic [11:0] rgb;
  logic        hso, vso;

  pixel_gen_rtc #(.X0(X0), .Y0(Y0), .FG(FG), .EDIT_FG(EFG), .BLINK_FRAMES(BF)) dut (
    .CLK(CLK), .RESET(RESET), .pixel_X(px), .pixel_Y(py), .hsync_in(hs), .vsync_in(vs),
    .hora(hora), .min(mn), .seg(sg), .edit_mode(edit), .campo_sel(campo),
    .rgb(rgb), .hsync_out(hso), .vsync_out(vso));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  int checks = 0, errors = 0;

  // values the next step applies to the time/edit inputs
  logic [7:0] t_h = '0, t_m = '0, t_s = '0;
  logic       t_edit = 1'b0;
  logic [1:0] t_campo = 2'd3;

  // reference model state
  logic [127:0] font [0:10];
  logic [7:0]   m_h, m_m, m_s;
  int           npulse;
  bit           prev_cond, was_rst;

  function automatic logic [11:0] ref_pixel(input int x, input int y);
    int ch, row, col, fld;
    logic [3:0]   nib;
    logic [127:0] g;
    logic [7:0]   bits;
    bit           blink_on, hit;
    if (x >= 640 || y >= 480) return 12'h000;
    if (x < X0 || x >= X0 + 256 || y < Y0 || y >= Y0 + 64) return 12'h000;
    ch  = (x - X0) / 32;
    row = (y - Y0) / 4;
    col = ((x - X0) / 4) % 8;
    fld = -1;
    if (ch == 2 || ch == 5) g = font[10];
    else begin
      case (ch)
        0: nib = m_h[7:4];
        1: nib = m_h[3:0];
        3: nib = m_m[7:4];
        4: nib = m_m[3:0];
        6: nib = m_s[7:4];
        default: nib = m_s[3:0];
      endcase
      g   = (nib <= 4'd9) ? font[nib] : 128'h0;
      fld = ch / 3;
    end
    bits     = g[8*(15-row) +: 8];
    blink_on = ((npulse / BF) % 2) == 0;
    hit      = edit && campo != 2'd3 && fld == int'(campo);
    if (!bits[7-col]) return 12'h000;
    if (hit) return blink_on ? EFG : 12'h000;
    return FG;
  endfunction

  task automatic push(input int due, input logic [11:0] r, input logic h, input logic v, input string tag);
    exp_t e;
    e.due = due; e.rgb = r; e.hs = h; e.vs = v; e.tag = tag;
    sbq.push_back(e);
  endtask

  // one clock of stimulus plus the model's view of it
  task automatic step(input bit r, input int x, input int y, input logic h, input logic v, input string tag);
    bit cond;
    @(negedge CLK);
    RESET = r; px = x[9:0]; py = y[9:0]; hs = h; vs = v;
    hora = t_h; mn = t_m; sg = t_s; edit = t_edit; campo = t_campo;
    if (r) begin
      // reset throws away anything still in flight
      while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
      push(cyc + 1, 12'h000, 1'b1, 1'b1, "reset");
      m_h = 0; m_m = 0; m_s = 0; npulse = 0; prev_cond = 0; was_rst = 1;
      return;
    end
    if (was_rst) push(cyc + 1, 12'h000, 1'b1, 1'b1, "release");
    was_rst = 0;
    push(cyc + 2, ref_pixel(x, y), h, v, tag);
    cond = (x == 0 && y == 480);
    if (cond && !prev_cond) begin
      m_h = t_h; m_m = t_m; m_s = t_s; npulse++;
    end
    prev_cond = cond;
  endtask

  task automatic pix(input int x, input int y, input string tag);
    step(0, x, y, 1'b1, 1'b1, tag);
  endtask

  task automatic box_pix(input int c0, input int c1, input string tag);
    step(0, X0 + 32*c0 + int'($urandom_range(0, 32*(c1-c0+1)-1)), Y0 + int'($urandom_range(0, 63)),
         $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, tag);
  endtask

  task automatic pulse();
    pix(3, 479, "pre_pulse");
    pix(0, 480, "pulse");
    pix(1, 480, "post_pulse");
  endtask

  // monitor: compare every queued expectation when its cycle comes up
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        checks++;
        if (rgb !== e.rgb || hso !== e.hs || vso !== e.vs) begin
          errors++;
          $display("FAIL %s cyc=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                   e.tag, cyc, rgb, hso, vso, e.rgb, e.hs, e.vs);
        end
      end
    end
  end

  initial begin
    font[0]  = 128'h00007CC6_C6CEDEF6_E6C6C67C_00000000;
    font[1]  = 128'h00001838_78181818_1818187E_00000000;
    font[2]  = 128'h00007CC6_060C1830_60C0C6FE_00000000;
    font[3]  = 128'h00007CC6_06063C06_0606C67C_00000000;
    font[4]  = 128'h00000C1C_3C6CCCFE_0C0C0C1E_00000000;
    font[5]  = 128'h0000FEC0_C0C0FC06_0606C67C_00000000;
    font[6]  = 128'h00003860_C0C0FCC6_C6C6C67C_00000000;
    font[7]  = 128'h0000FEC6_06060C18_30303030_00000000;
    font[8]  = 128'h00007CC6_C6C67CC6_C6C6C67C_00000000;
    font[9]  = 128'h00007CC6_C6C67E06_06060C78_00000000;
    font[10] = 128'h00000000_18180000_00001818_00000000;
    m_h = 0; m_m = 0; m_s = 0; npulse = 0; prev_cond = 0; was_rst = 0;

    // reset with arbitrary inputs
    for (int i = 0; i < 3; i++) begin
      t_h = 8'($urandom); t_m = 8'($urandom); t_s = 8'($urandom);
      step(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom), 1'($urandom), "reset");
    end
    // before any frame pulse the display reads 00:00:00
    t_h = 8'h12; t_m = 8'h34; t_s = 8'h56; t_edit = 0; t_campo = 3;
    for (int i = 0; i < 150; i++) box_pix(0, 7, "pre_frame");
    // colon pixel on and off
    for (int i = 0; i < 3; i++) pix(268, 224, "colon_on");
    for (int i = 0; i < 3; i++) pix(268, 208, "colon_off");
    // box and screen boundaries
    pix(X0 - 1, Y0 + 20, "edge"); pix(X0 + 256, Y0 + 20, "edge"); pix(X0, Y0 - 1, "edge");
    pix(X0, Y0 + 64, "edge"); pix(X0 + 255, Y0 + 63, "edge"); pix(639, 479, "edge");
    pix(640, 0, "edge"); pix(1023, 1023, "edge");

    // shadowing: seg changes mid-frame only shows after the next pulse
    t_s = 8'h41; pulse();
    for (int i = 0; i < 80; i++) box_pix(6, 7, "shadow_old");
    t_s = 8'h42; pix(5, 100, "line100");
    for (int i = 0; i < 80; i++) box_pix(6, 7, "shadow_hold");
    pulse();
    for (int i = 0; i < 80; i++) box_pix(6, 7, "shadow_new");

    // blink of the minutes field; hours stay normal
    t_h = 8'h88; t_m = 8'h88; t_edit = 1; t_campo = 1;
    for (int f = 0; f < 62; f++) begin
      pulse();
      for (int i = 0; i < 10; i++) box_pix(3, 4, "blink_min");
      for (int i = 0; i < 4; i++) box_pix(0, 1, "blink_hour");
    end

    // invalid BCD blanks character 0; off-screen pixel; hsync pulse delay
    t_edit = 0; t_campo = 3; t_h = 8'hA5; pulse();
    for (int y = 0; y < 64; y += 2)
      for (int x = 0; x < 32; x++) pix(X0 + x, Y0 + y, "bad_bcd");
    pix(700, 210, "offscreen");
    step(0, 100, 100, 1'b1, 1'b1, "hs_pre");
    step(0, 100, 100, 1'b0, 1'b1, "hs_low");
    step(0, 100, 100, 1'b1, 1'b1, "hs_post");

    // random soak: values, edits, frame pulses and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        t_edit = 1'($urandom); t_campo = 2'($urandom);
        t_h = 8'($urandom); t_m = 8'($urandom); t_s = 8'($urandom);
      end
      if ($urandom_range(0, 49) == 0) pulse();
      else if ($urandom_range(0, 499) == 0) begin
        step(1, 0, 0, 1'b0, 1'b0, "reset");
        step(1, 0, 480, 1'b0, 1'b0, "reset");
      end else if ($urandom_range(0, 1) == 0) box_pix(0, 7, "rand_box");
      else step(0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                1'($urandom), 1'($urandom), "rand_any");
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge CLK);
    #5;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
